// File: rtl/ram_pkg.sv
// Shared constants for the MIPS data RAM and the upstream data-memory decode.
package ram_pkg;

   localparam int          RAM_WORDS  = 3072;
   localparam int          RAM_ADDR_W = 14;
   localparam int          RAM_WORD_W = 32;
   localparam logic [15:0] RAM_LIMIT  = 16'h3000;

endpackage : ram_pkg

// File: rtl/ram_addr_decode.sv
// Word-index extraction and range test for the data RAM.
// WRAP=1 folds the index modulo WORDS and reports every access as in range.
module ram_addr_decode #(
   parameter int WORDS  = 3072,
   parameter int ADDR_W = 14,
   parameter bit WRAP   = 1'b0
) (
   input  logic [ADDR_W-3:0] i_word_idx,
   output logic [ADDR_W-3:0] o_idx,
   output logic              o_in_range
);

   localparam int IDX_W = ADDR_W - 2;
   localparam bit FULL  = (WORDS >= (1 << IDX_W));

   // A power-of-two store spanning the whole index space needs no folding.
   generate
      if (WRAP && !FULL) begin : g_wrap
         assign o_idx      = i_word_idx % IDX_W'(WORDS);
         assign o_in_range = 1'b1;
      end else if (WRAP || FULL) begin : g_all
         assign o_idx      = i_word_idx;
         assign o_in_range = 1'b1;
      end else begin : g_check
         assign o_idx      = i_word_idx;
         assign o_in_range = (i_word_idx < IDX_W'(WORDS));
      end
   endgenerate

endmodule : ram_addr_decode

// File: rtl/ram.sv
// Word-organised data RAM: combinational read, synchronous full-word write,
// asynchronous clear. Build option: RAM_RANGE_CHECK_EN enables the range check.
module ram
   import ram_pkg::*;
#(
   parameter int WORDS  = RAM_WORDS,
   parameter int ADDR_W = RAM_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     address,
   input  logic                  readEnable,
   input  logic                  writeEnable,
   input  logic [RAM_WORD_W-1:0] writeDataIn,
   output logic [RAM_WORD_W-1:0] readData,
   output logic                  exception
);

   localparam int IDX_W = ADDR_W - 2;
`ifdef RAM_RANGE_CHECK_EN
   localparam bit WRAP = 1'b0;
`else
   localparam bit WRAP = 1'b1;
`endif

   logic [RAM_WORD_W-1:0] r_mem [WORDS];
   logic [IDX_W-1:0]      w_idx;
   logic                  w_in_range;
   logic                  w_unused;

   // Byte-offset bits are deliberately ignored; merging happens upstream.
   assign w_unused = ^address[1:0];

   ram_addr_decode #(
      .WORDS  (WORDS),
      .ADDR_W (ADDR_W),
      .WRAP   (WRAP)
   ) u_decode (
      .i_word_idx (address[ADDR_W-1:2]),
      .o_idx      (w_idx),
      .o_in_range (w_in_range)
   );

   // Combinational read port, zero when deselected or out of range.
   always_comb begin
      readData = {RAM_WORD_W{1'b0}};
      if (readEnable && w_in_range) begin
         readData = r_mem[w_idx];
      end else begin
         readData = {RAM_WORD_W{1'b0}};
      end
   end

`ifdef RAM_RANGE_CHECK_EN
   assign exception = (readEnable | writeEnable) & ~w_in_range;
`else
   assign exception = 1'b0;
`endif

   // Storage: asynchronous clear has priority over any write on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) begin
            r_mem[i] <= {RAM_WORD_W{1'b0}};
         end
      end else if (writeEnable && w_in_range) begin
         r_mem[w_idx] <= writeDataIn;
      end
   end

endmodule : ram

// File: tb/tb_ram.sv
// Directed self-checking bench for ram; expectations follow the build option
// RAM_RANGE_CHECK_EN (checked vs. wrapping index).
module tb_ram;

   logic        clk;
   logic        reset;
   logic [13:0] address;
   logic        readEnable;
   logic        writeEnable;
   logic [31:0] writeDataIn;
   logic [31:0] readData;
   logic        exception;

   int n_tests;
   int n_fail;

   ram dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .readEnable  (readEnable),
      .writeEnable (writeEnable),
      .writeDataIn (writeDataIn),
      .readData    (readData),
      .exception   (exception)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [13:0] a, input logic [31:0] d);
      @(negedge clk);
      address     = a;
      writeDataIn = d;
      writeEnable = 1'b1;
      readEnable  = 1'b0;
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] addrs [3];
      addrs[0] = 14'h0000;
      addrs[1] = 14'h1FFC;
      addrs[2] = 14'h2FFC;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      readEnable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         address = addrs[i];
         #1;
         n_tests++;
         if (readData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], readData, 32'h0);
         end
         n_tests++;
         if (exception !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_exc addr=%h got=%b exp=0", addrs[i], exception);
         end
      end
      @(negedge clk);
      reset      = 1'b0;
      readEnable = 1'b0;
   endtask

   task automatic test_write_read();
      do_write(14'h0104, 32'hDEADBEEF);
      readEnable = 1'b1;
      address    = 14'h0104;
      #1;
      n_tests++;
      if (readData !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_rd_0104 got=%h exp=%h", readData, 32'hDEADBEEF);
      end
      address = 14'h0107;
      #1;
      n_tests++;
      if (readData !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_rd_0107 got=%h exp=%h", readData, 32'hDEADBEEF);
      end
      readEnable = 1'b0;
   endtask

   task automatic test_same_cycle();
      do_write(14'h0200, 32'hDEADBEEF);
      @(negedge clk);
      address     = 14'h0200;
      writeDataIn = 32'h12345678;
      writeEnable = 1'b1;
      readEnable  = 1'b1;
      #1;
      n_tests++;
      if (readData !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rdw_before got=%h exp=%h", readData, 32'hDEADBEEF);
      end
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      n_tests++;
      if (readData !== 32'h12345678) begin
         n_fail++;
         $display("FAIL rdw_after got=%h exp=%h", readData, 32'h12345678);
      end
      readEnable = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      address     = 14'h0020;
      writeDataIn = 32'h11111111;
      writeEnable = 1'b1;
      @(negedge clk);
      writeDataIn = 32'h22222222;
      @(negedge clk);
      address     = 14'h0024;
      writeDataIn = 32'h33333333;
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      readEnable  = 1'b1;
      address     = 14'h0020;
      #1;
      n_tests++;
      if (readData !== 32'h22222222) begin
         n_fail++;
         $display("FAIL b2b_last_wins got=%h exp=%h", readData, 32'h22222222);
      end
      address = 14'h0024;
      #1;
      n_tests++;
      if (readData !== 32'h33333333) begin
         n_fail++;
         $display("FAIL b2b_next_addr got=%h exp=%h", readData, 32'h33333333);
      end
      readEnable = 1'b0;
   endtask

   task automatic test_range();
      logic        exp_exc;
      logic [31:0] exp_w0;
`ifdef RAM_RANGE_CHECK_EN
      exp_exc = 1'b1;
      exp_w0  = 32'h0;
`else
      exp_exc = 1'b0;
      exp_w0  = 32'hCAFEF00D;
`endif
      @(negedge clk);
      address     = 14'h3000;
      writeDataIn = 32'hCAFEF00D;
      writeEnable = 1'b1;
      readEnable  = 1'b0;
      #1;
      n_tests++;
      if (exception !== exp_exc) begin
         n_fail++;
         $display("FAIL range_wr_exc got=%b exp=%b", exception, exp_exc);
      end
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      readEnable  = 1'b1;
      address     = 14'h0000;
      #1;
      n_tests++;
      if (readData !== exp_w0) begin
         n_fail++;
         $display("FAIL range_word0 got=%h exp=%h", readData, exp_w0);
      end
      address = 14'h3FFC;
      #1;
      n_tests++;
      if (exception !== exp_exc) begin
         n_fail++;
         $display("FAIL range_rd_exc got=%b exp=%b", exception, exp_exc);
      end
      n_tests++;
      if (readData !== 32'h0) begin
         n_fail++;
         $display("FAIL range_rd_data got=%h exp=%h", readData, 32'h0);
      end
      readEnable = 1'b0;
      address    = 14'h3000;
      #1;
      n_tests++;
      if (exception !== 1'b0) begin
         n_fail++;
         $display("FAIL range_idle_exc got=%b exp=0", exception);
      end
   endtask

   task automatic test_disabled_read();
      address    = 14'h0104;
      readEnable = 1'b0;
      #1;
      n_tests++;
      if (readData !== 32'h0) begin
         n_fail++;
         $display("FAIL rd_disabled got=%h exp=%h", readData, 32'h0);
      end
   endtask

   task automatic test_async_reset();
      do_write(14'h0010, 32'hA5A5A5A5);
      readEnable = 1'b1;
      address    = 14'h0010;
      #1;
      n_tests++;
      if (readData !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL areset_pre got=%h exp=%h", readData, 32'hA5A5A5A5);
      end
      #1;
      reset = 1'b1;
      #1;
      n_tests++;
      if (readData !== 32'h0) begin
         n_fail++;
         $display("FAIL areset_clear got=%h exp=%h", readData, 32'h0);
      end
      reset = 1'b0;
      address = 14'h0104;
      #1;
      n_tests++;
      if (readData !== 32'h0) begin
         n_fail++;
         $display("FAIL areset_other got=%h exp=%h", readData, 32'h0);
      end
      readEnable = 1'b0;
   endtask

   task automatic test_write_during_reset();
      @(negedge clk);
      reset       = 1'b1;
      address     = 14'h0040;
      writeDataIn = 32'h5A5A5A5A;
      writeEnable = 1'b1;
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      @(negedge clk);
      reset      = 1'b0;
      readEnable = 1'b1;
      #1;
      n_tests++;
      if (readData !== 32'h0) begin
         n_fail++;
         $display("FAIL wr_in_reset got=%h exp=%h", readData, 32'h0);
      end
      readEnable = 1'b0;
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      reset       = 1'b1;
      address     = 14'h0;
      readEnable  = 1'b0;
      writeEnable = 1'b0;
      writeDataIn = 32'h0;
      test_reset();
      test_write_read();
      test_same_cycle();
      test_back_to_back();
      test_range();
      test_disabled_read();
      test_async_reset();
      test_write_during_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ram
